// File: rtl/reg_nway_mux.sv
`timescale 1ns / 1ps
// reg_nway_mux
//
// Registered N-to-1 datapath multiplexer with valid/ready flow control and a
// two-entry skid buffer. One channel of in_bus is picked by in_sel at each
// accepted transfer and delivered in FIFO order on out_data.
//
// A transfer whose select is out of range (in_sel >= NUM_INPUTS) still
// completes its handshake, but it stores nothing and sets err_sticky.
//
// Optional feature macro: MUX_ERRCNT_EN. When it is defined, the err_count
// port is added. It is an 8-bit saturating count of dropped transfers.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_bus     flattened channels; channel i at in_bus[i*BUS_WIDTH +: BUS_WIDTH]
//   in_sel     channel index, sampled with in_valid
//   in_valid   upstream transfer request
//   in_ready   block can accept a transfer this cycle
//   out_data   registered selected data (head of the buffer)
//   out_valid  out_data holds a pending result
//   out_ready  downstream accepts out_data this cycle
//   err_sticky an out-of-range select was accepted since the last clear
//   err_clr    clears err_sticky (and err_count when built in)
//   err_count  (MUX_ERRCNT_EN only) saturating dropped-transfer count
module reg_nway_mux #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUTS*BUS_WIDTH-1:0] in_bus,
  input  logic [SEL_WIDTH-1:0]            in_sel,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BUS_WIDTH-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            err_sticky,
`ifdef MUX_ERRCNT_EN
  input  logic                            err_clr,
  output logic [7:0]                      err_count
`else
  input  logic                            err_clr
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] main_q, main_d;
  logic [BUS_WIDTH-1:0] skid_q, skid_d;
  logic                 err_sticky_q, err_sticky_d;

  logic [BUS_WIDTH-1:0] payload;
  logic                 sel_ok;
  logic                 push;
  logic                 push_ok;
  logic                 drop;
  logic                 pop;

  // Handshake outputs come only from the state register.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign err_sticky = err_sticky_q;

  assign sel_ok  = (32'(in_sel) < NUM_INPUTS);
  assign push    = in_valid && in_ready;
  assign push_ok = push && sel_ok;
  assign drop    = push && !sel_ok;
  assign pop     = out_valid && out_ready;

  // Channel select. An out-of-range select yields zero, but the result is never stored.
  always_comb begin
    payload = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (32'(in_sel) == i) begin
        payload = in_bus[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (push_ok) begin
          main_d  = payload;
          state_d = StOne;
        end
      end
      StOne: begin
        if (pop && push_ok) begin
          main_d = payload;
        end else if (pop) begin
          state_d = StEmpty;
        end else if (push_ok) begin
          skid_d  = payload;
          state_d = StFull;
        end
      end
      StFull: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // A set takes priority over a clear in the same cycle.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (drop) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StEmpty;
      main_q       <= '0;
      skid_q       <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef MUX_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  assign err_count = err_count_q;

  // A clear that coincides with a drop leaves a count of one.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end
`endif

endmodule
